frame_copy_master: RTL
======================

# frame_copy_master

Parametrised SRAM-to-SDRAM frame copy engine for the 2D GPU FPGA top. It is programmed through an Avalon-MM CSR slave, which the PCIe bridge drives. It reads wide pixel words from the on-chip frame SRAM, unpacks each word into individual pixels, and writes them one per beat through an Avalon-MM master into the SDRAM frame buffer. It replaces fixed-geometry copy logic with configurable pixel width, pixels per word, SRAM latency, destination stride and an address-limit check.

## Interface
Parameters:
- MASTER_ADDRESSWIDTH, 26: Avalon master address width.
- SLAVE_ADDRESSWIDTH, 3: CSR address width (8 registers).
- DATAWIDTH, 32: master and slave data width.
- PIXEL_WIDTH, 24: bits per pixel. Must be ≤ DATAWIDTH.
- PIXELS_PER_WORD, 64: pixels packed in one SRAM word.
- SRAM_ADDRWIDTH, 24: SRAM word address width.
- SRAM_READ_LATENCY, 1: cycles from sram_read_enable to valid sram_read_data. Must be ≥ 1.
- DEFAULT_STEP, 4: reset value of DST_STEP, in bytes.

Ports:
- clk  in  1  clock. One clock; every port is synchronous to it.
- reset  in  1  synchronous, active-high reset.
- slave_address  in  SLAVE_ADDRESSWIDTH  CSR index.
- slave_writedata  in  DATAWIDTH  CSR write data.
- slave_write, slave_read, slave_chipselect  in  1 each  Avalon slave strobes.
- slave_readdata  out  DATAWIDTH  registered CSR read data.
- sram_req  out  1  high while the engine owns the SRAM port; drives the SRAM mux select.
- sram_read_enable  out  1  one-cycle SRAM read strobe.
- sram_address  out  SRAM_ADDRWIDTH  SRAM word address.
- sram_read_data  in  PIXEL_WIDTH*PIXELS_PER_WORD  SRAM read word. Pixel i occupies bits [i*PIXEL_WIDTH +: PIXEL_WIDTH].
- master_address  out  MASTER_ADDRESSWIDTH  SDRAM byte address.
- master_writedata  out  DATAWIDTH  pixel, zero-extended.
- master_write  out  1  write request.
- master_waitrequest  in  1  Avalon backpressure.
- busy  out  1  high from accepted start until return to IDLE.
- irq  out  1  present only with FCM_IRQ_EN (see Configuration).

## Operation
CSR map (word index):
- 0 CTRL: bit0 START and bit1 ABORT are write-1 pulses and read back as 0. bit2 IRQ_EN is a stored bit.
- 1 STATUS, read-only: bit0 busy, bit1 done, bit2 aborted, bit3 error.
  - bits 1–3 are sticky. They are cleared by an accepted START, or by writing 1 to the matching bit of STATUS.
- 2 SRC_BASE: SRAM start word.
- 3 WORD_COUNT: number of SRAM words to copy.
- 4 DST_BASE: SDRAM start byte address.
- 5 DST_STEP: byte increment per pixel.
- 6 PIXELS_WRITTEN, read-only: count of pixels written since the last start.
- 7 DST_LIMIT: last legal destination address, inclusive.

CSR rules:
- All CSRs reset to 0, except DST_STEP, which resets to DEFAULT_STEP.
- CSR writes to regs 2–5 and 7 while busy are ignored.

FSM: IDLE → SRAM_REQ → SRAM_WAIT → WRITE → (SRAM_REQ | DONE) → IDLE.
- **IDLE**:
  - On START with ABORT=0:
    - Load the working registers: src←SRC_BASE, dst←DST_BASE, words←WORD_COUNT, PIXELS_WRITTEN←0.
    - Clear the sticky status bits.
  - If WORD_COUNT=0, go to DONE with no bus traffic. Otherwise go to SRAM_REQ.
  - START while busy is ignored.
- **SRAM_REQ**: sram_req=1, sram_read_enable=1, sram_address=src for 1 cycle.
- **SRAM_WAIT**:
  - sram_req=1. Wait SRAM_READ_LATENCY cycles, then capture sram_read_data into the word buffer. pix←0.
- **WRITE**:
  - master_write=1, master_address=dst, master_writedata={zeros, buffer pixel[pix]}.
  - Before each new beat, if dst > DST_LIMIT: do not assert master_write, set error, go to IDLE.
  - On a cycle with !master_waitrequest (beat accepted):
    - dst += DST_STEP (wraps modulo 2^MASTER_ADDRESSWIDTH).
    - PIXELS_WRITTEN++.
    - If pix = PIXELS_PER_WORD-1: words--, src++ (wraps modulo 2^SRAM_ADDRWIDTH). Go to DONE if words reaches 0, else SRAM_REQ.
    - Otherwise pix++.
- **DONE**: set done, go to IDLE.

ABORT:
- In SRAM_REQ or SRAM_WAIT it takes effect at the next edge.
- In WRITE, address and data stay stable until the pending beat is accepted; the engine then stops.
- On abort: set aborted, clear done, go to IDLE.
- START and ABORT written together: ABORT wins, START is ignored.

Reset at any time, including mid-burst:
- All outputs drop to 0 at the next edge.
- FSM goes to IDLE; CSRs take their reset values.

## Timing
- slave_readdata is valid 1 cycle after slave_read && slave_chipselect. It holds its value otherwise.
- START written at edge t: SRAM_REQ in cycle t+1; first master_write in cycle t+2+SRAM_READ_LATENCY.
- With no backpressure, each word takes 1+SRAM_READ_LATENCY+PIXELS_PER_WORD cycles.
- DONE lasts 1 cycle. busy falls the cycle after DONE.
- master_address and master_writedata are constant while master_write && master_waitrequest.

## Configuration
- FCM_IRQ_EN defined:
  - irq port exists and is registered.
  - irq is set when done, aborted or error becomes 1 while IRQ_EN=1.
  - irq stays high until the causing STATUS bits are cleared.
- FCM_IRQ_EN undefined:
  - No irq port. CTRL bit2 reads 0 and writes to it are ignored.
  - Software must poll STATUS.

## Test plan
All scenarios use PIXEL_WIDTH=24, PIXELS_PER_WORD=4, SRAM_READ_LATENCY=1.
- Basic copy:
  - Stimulus: SRAM[5]={0x444444,0x333333,0x222222,0x111111}; SRC_BASE=5, WORD_COUNT=1, DST_BASE=0x1000, START.
  - Response: writes (0x1000,0x00111111), (0x1004,0x00222222), (0x1008,0x00333333), (0x100C,0x00444444); STATUS=0x2; PIXELS_WRITTEN=4.
- Backpressure:
  - Stimulus: 2 words; master_waitrequest held 3 cycles on every beat.
  - Response: 8 writes, no duplicates or skips; address and data stable during every stall.
- Zero count:
  - Stimulus: WORD_COUNT=0, START.
  - Response: no sram_read_enable, no master_write; done set 2 cycles later.
- Limit:
  - Stimulus: DST_BASE=0x1000, DST_LIMIT=0x1004.
  - Response: exactly 2 writes, then error=1 and busy=0.
- Abort:
  - Stimulus: ABORT during a stalled beat.
  - Response: the stalled beat completes, no further writes, aborted=1, done=0.
  - Stimulus: START+ABORT written together from IDLE.
  - Response: no activity.
- Reset mid-copy:
  - Stimulus: reset asserted during WRITE.
  - Response: master_write=0 and busy=0 next cycle; CSRs back to reset values.
  - With FCM_IRQ_EN: irq=0 after reset; irq=1 after DONE when IRQ_EN=1.

Source files
------------

// File: rtl/frame_copy_master_if.sv
// Avalon-MM write-master bus between the frame copy engine and the SDRAM side.
// Latency: none, wires only.
// Backpressure: the slave side holds master_waitrequest to stall the current beat.
interface frame_copy_master_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0] master_address;
  logic [DATA_W-1:0] master_writedata;
  logic              master_write;
  logic              master_waitrequest;

  modport master (
    output master_address,
    output master_writedata,
    output master_write,
    input  master_waitrequest
  );

  modport slave (
    input  master_address,
    input  master_writedata,
    input  master_write,
    output master_waitrequest
  );
endinterface

// File: rtl/frame_copy_master.sv
// SRAM-to-SDRAM frame copy engine: reads packed pixel words from SRAM and
// writes one zero-extended pixel per Avalon beat. Per word: 1 + SRAM_READ_LATENCY
// + PIXELS_PER_WORD cycles without stalls. A beat is held stable while
// master_waitrequest is high. Optional FCM_IRQ_EN adds a registered irq output.
module frame_copy_master #(
  parameter int MASTER_ADDRESSWIDTH = 26,
  parameter int SLAVE_ADDRESSWIDTH  = 3,
  parameter int DATAWIDTH           = 32,
  parameter int PIXEL_WIDTH         = 24,
  parameter int PIXELS_PER_WORD     = 64,
  parameter int SRAM_ADDRWIDTH      = 24,
  parameter int SRAM_READ_LATENCY   = 1,
  parameter int DEFAULT_STEP        = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [SLAVE_ADDRESSWIDTH-1:0]          slave_address,
  input  logic [DATAWIDTH-1:0]                   slave_writedata,
  input  logic                                   slave_write,
  input  logic                                   slave_read,
  input  logic                                   slave_chipselect,
  output logic [DATAWIDTH-1:0]                   slave_readdata,
  output logic                                   sram_req,
  output logic                                   sram_read_enable,
  output logic [SRAM_ADDRWIDTH-1:0]              sram_address,
  input  logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] sram_read_data,
  frame_copy_master_if.master                    avm,
  output logic                                   busy
`ifdef FCM_IRQ_EN
  ,
  output logic                                   irq
`endif
);

  localparam int WORD_W = PIXEL_WIDTH * PIXELS_PER_WORD;
  localparam int PIX_W  = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;
  localparam int LAT_W  = (SRAM_READ_LATENCY > 1) ? $clog2(SRAM_READ_LATENCY) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS_PER_WORD - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(SRAM_READ_LATENCY - 1);

  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_CTRL   = SLAVE_ADDRESSWIDTH'(0);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_STATUS = SLAVE_ADDRESSWIDTH'(1);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_SRC    = SLAVE_ADDRESSWIDTH'(2);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_COUNT  = SLAVE_ADDRESSWIDTH'(3);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_DST    = SLAVE_ADDRESSWIDTH'(4);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_STEP   = SLAVE_ADDRESSWIDTH'(5);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_PIXW   = SLAVE_ADDRESSWIDTH'(6);
  localparam logic [SLAVE_ADDRESSWIDTH-1:0] A_LIMIT  = SLAVE_ADDRESSWIDTH'(7);

  typedef enum logic [2:0] {
    S_IDLE, S_SRAM_REQ, S_SRAM_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t state;

  // programmed configuration
  logic [DATAWIDTH-1:0] src_base, word_count, dst_base, dst_step, dst_limit;
  logic                 ctrl_irq_en;

  // sticky status and progress
  logic                 st_done, st_aborted, st_error;
  logic [DATAWIDTH-1:0] pixels_written;

  // working registers
  logic [SRAM_ADDRWIDTH-1:0]      src;
  logic [MASTER_ADDRESSWIDTH-1:0] dst;
  logic [DATAWIDTH-1:0]           words;
  logic [PIX_W-1:0]               pix;
  logic [LAT_W-1:0]               wait_cnt;
  logic [WORD_W-1:0]              word_buf;
  logic                           abort_pend;
  logic                           mw;
  logic [DATAWIDTH-1:0]           mwd;

  logic                           wr, wr_ctrl, wr_status, start_req, abort_req;
  logic [MASTER_ADDRESSWIDTH-1:0] dst_next;
  logic [PIX_W-1:0]               pix_next;
  logic [DATAWIDTH-1:0]           csr_rdata;

  assign wr        = slave_write & slave_chipselect;
  assign wr_ctrl   = wr && (slave_address == A_CTRL);
  assign wr_status = wr && (slave_address == A_STATUS);
  assign start_req = wr_ctrl & slave_writedata[0];
  assign abort_req = wr_ctrl & slave_writedata[1];
  assign dst_next  = dst + MASTER_ADDRESSWIDTH'(dst_step);
  assign pix_next  = pix + 1'b1;

  assign avm.master_address   = dst;
  assign avm.master_writedata = mwd;
  assign avm.master_write     = mw;

  // destination beyond the inclusive limit; both sides zero-extended
  function automatic logic over_limit(input logic [MASTER_ADDRESSWIDTH-1:0] a);
    return 64'(a) > 64'(dst_limit);
  endfunction

  // configuration registers; geometry is frozen while a copy runs
  always_ff @(posedge clk) begin
    if (reset) begin
      src_base   <= '0;
      word_count <= '0;
      dst_base   <= '0;
      dst_step   <= DATAWIDTH'(DEFAULT_STEP);
      dst_limit  <= '0;
    end else if (wr && !busy) begin
      case (slave_address)
        A_SRC:   src_base   <= slave_writedata;
        A_COUNT: word_count <= slave_writedata;
        A_DST:   dst_base   <= slave_writedata;
        A_STEP:  dst_step   <= slave_writedata;
        A_LIMIT: dst_limit  <= slave_writedata;
        default: ;
      endcase
    end
  end

`ifdef FCM_IRQ_EN
  logic [2:0] sticky_d;

  // interrupt enable is writable at any time
  always_ff @(posedge clk) begin
    if (reset) ctrl_irq_en <= 1'b0;
    else if (wr_ctrl) ctrl_irq_en <= slave_writedata[2];
  end

  // raise on a newly set status bit while enabled, hold until all causes clear
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_d <= '0;
      irq      <= 1'b0;
    end else begin
      sticky_d <= {st_error, st_aborted, st_done};
      irq      <= (|{st_error, st_aborted, st_done}) &&
                  (irq || (ctrl_irq_en &&
                   |({st_error, st_aborted, st_done} & ~sticky_d)));
    end
  end
`else
  assign ctrl_irq_en = 1'b0;
`endif

  // CSR read mux
  always_comb begin
    csr_rdata = '0;
    case (slave_address)
      A_CTRL:   csr_rdata[2]   = ctrl_irq_en;
      A_STATUS: csr_rdata[3:0] = {st_error, st_aborted, st_done, busy};
      A_SRC:    csr_rdata      = src_base;
      A_COUNT:  csr_rdata      = word_count;
      A_DST:    csr_rdata      = dst_base;
      A_STEP:   csr_rdata      = dst_step;
      A_PIXW:   csr_rdata      = pixels_written;
      A_LIMIT:  csr_rdata      = dst_limit;
      default:  ;
    endcase
  end

  // registered read data, held between reads
  always_ff @(posedge clk) begin
    if (reset) slave_readdata <= '0;
    else if (slave_read && slave_chipselect) slave_readdata <= csr_rdata;
  end

  // copy sequencer; all bus outputs are registered here
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      sram_req         <= 1'b0;
      sram_read_enable <= 1'b0;
      sram_address     <= '0;
      mw               <= 1'b0;
      mwd              <= '0;
      src              <= '0;
      dst              <= '0;
      words            <= '0;
      pix              <= '0;
      wait_cnt         <= '0;
      word_buf         <= '0;
      abort_pend       <= 1'b0;
      st_done          <= 1'b0;
      st_aborted       <= 1'b0;
      st_error         <= 1'b0;
      pixels_written   <= '0;
    end else begin
      // software clears come first so a same-cycle hardware set wins
      if (wr_status) begin
        if (slave_writedata[1]) st_done    <= 1'b0;
        if (slave_writedata[2]) st_aborted <= 1'b0;
        if (slave_writedata[3]) st_error   <= 1'b0;
      end

      if (abort_req && (state == S_SRAM_REQ || state == S_SRAM_WAIT)) begin
        sram_req         <= 1'b0;
        sram_read_enable <= 1'b0;
        st_aborted       <= 1'b1;
        st_done          <= 1'b0;
        busy             <= 1'b0;
        state            <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_req && !abort_req) begin
              src            <= SRAM_ADDRWIDTH'(src_base);
              dst            <= MASTER_ADDRESSWIDTH'(dst_base);
              words          <= word_count;
              pixels_written <= '0;
              st_done        <= 1'b0;
              st_aborted     <= 1'b0;
              st_error       <= 1'b0;
              abort_pend     <= 1'b0;
              busy           <= 1'b1;
              if (word_count == '0) begin
                state <= S_DONE;
              end else begin
                state            <= S_SRAM_REQ;
                sram_req         <= 1'b1;
                sram_read_enable <= 1'b1;
                sram_address     <= SRAM_ADDRWIDTH'(src_base);
              end
            end
          end

          S_SRAM_REQ: begin
            sram_read_enable <= 1'b0;
            wait_cnt         <= LAT_LAST;
            state            <= S_SRAM_WAIT;
          end

          S_SRAM_WAIT: begin
            if (wait_cnt != '0) begin
              wait_cnt <= wait_cnt - 1'b1;
            end else begin
              word_buf <= sram_read_data;
              pix      <= '0;
              sram_req <= 1'b0;
              if (over_limit(dst)) begin
                st_error <= 1'b1;
                busy     <= 1'b0;
                state    <= S_IDLE;
              end else begin
                mw    <= 1'b1;
                mwd   <= DATAWIDTH'(sram_read_data[0 +: PIXEL_WIDTH]);
                state <= S_WRITE;
              end
            end
          end

          S_WRITE: begin
            if (!avm.master_waitrequest) begin
              dst            <= dst_next;
              pixels_written <= pixels_written + 1'b1;
              if (abort_pend || abort_req) begin
                mw         <= 1'b0;
                abort_pend <= 1'b0;
                st_aborted <= 1'b1;
                st_done    <= 1'b0;
                busy       <= 1'b0;
                state      <= S_IDLE;
              end else if (pix == PIX_LAST) begin
                mw    <= 1'b0;
                src   <= src + 1'b1;
                words <= words - 1'b1;
                if (words == DATAWIDTH'(1)) begin
                  state <= S_DONE;
                end else begin
                  state            <= S_SRAM_REQ;
                  sram_req         <= 1'b1;
                  sram_read_enable <= 1'b1;
                  sram_address     <= src + 1'b1;
                end
              end else if (over_limit(dst_next)) begin
                mw       <= 1'b0;
                st_error <= 1'b1;
                busy     <= 1'b0;
                state    <= S_IDLE;
              end else begin
                pix <= pix_next;
                mwd <= DATAWIDTH'(word_buf[int'(pix_next)*PIXEL_WIDTH +: PIXEL_WIDTH]);
              end
            end else if (abort_req) begin
              // the stalled beat must still complete unchanged
              abort_pend <= 1'b1;
            end
          end

          S_DONE: begin
            st_done <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
